// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares the single Execute-stage ALU between the pipeline
// execute slot (port 0) and an auxiliary unit (port 1). Requests are granted
// round-robin, issued to the ALU for one cycle, and the registered ALU result
// is returned one cycle later tagged with the requester ID.
//
// Optional feature macro: ALU_SHARE_CCR_EN
//   defined   -> {C,N,Z} condition-code register updated from the ALU flags
//   undefined -> no CCR flops, ccr reads as 3'b000
module alu_share_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             alu_en,
  output logic [3:0]       alu_func,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_c,
  input  logic             alu_n,
  input  logic             alu_z,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic [2:0]       ccr
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  localparam logic [3:0] OP_LDD = 4'b0001;
  localparam logic [3:0] OP_STD = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_NOT = 4'b0100;
  localparam logic [3:0] OP_NOP = 4'b0101;

  logic [1:0]       state;
  logic             prio;      // port that wins when both request
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             id_q;
  logic             err_q;

  logic             grant;
  logic             winner;
  logic [3:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_legal;

  // Arbitration: ready is a Mealy output of IDLE and the valids, held off in reset.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first,
    // otherwise a missed branch infers a latch.
    grant      = 1'b0;
    winner     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (reset && (state == IDLE) && (req0_valid || req1_valid)) begin
      grant      = 1'b1;
      winner     = (req0_valid && req1_valid) ? prio : req1_valid;
      req0_ready = ~winner;
      req1_ready = winner;
    end
    sel_op    = winner ? req1_op : req0_op;
    sel_a     = winner ? req1_a  : req0_a;
    sel_b     = winner ? req1_b  : req0_b;
    sel_legal = (sel_op == OP_LDD) || (sel_op == OP_STD) || (sel_op == OP_ADD) ||
                (sel_op == OP_NOT) || (sel_op == OP_NOP);
  end

  // Sequencer: IDLE -> ISSUE -> CAPTURE, latching the granted request.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset) begin
      state <= IDLE;
      prio  <= 1'b0;
      op_q  <= OP_NOP;
      a_q   <= '0;
      b_q   <= '0;
      id_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state <= ISSUE;
            prio  <= ~winner;
            op_q  <= sel_op;
            a_q   <= sel_a;
            b_q   <= sel_b;
            id_q  <= winner;
            err_q <= ~sel_legal;
          end
        end
        ISSUE:   state <= CAPTURE;
        CAPTURE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // ALU drive and response are decoded from state and the latched request.
  always_comb begin
    alu_en    = 1'b0;
    alu_func  = OP_NOP;
    alu_a     = '0;
    alu_b     = '0;
    rsp_valid = 1'b0;
    rsp_id    = 1'b0;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    if ((state == ISSUE) && !err_q) begin
      alu_en   = 1'b1;
      alu_func = op_q;
      alu_a    = a_q;
      alu_b    = b_q;
    end
    if (state == CAPTURE) begin
      rsp_valid = 1'b1;
      rsp_id    = id_q;
      rsp_data  = err_q ? '0 : alu_out;
      rsp_err   = err_q;
    end
  end

`ifdef ALU_SHARE_CCR_EN
  logic [2:0] ccr_q;

  // CCR loads on the CAPTURE edge for ADD (full flags) and NOT (carry cleared).
  always_ff @(posedge clk) begin
    if (!reset) begin
      ccr_q <= 3'b000;
    end else if ((state == CAPTURE) && !err_q) begin
      if (op_q == OP_ADD) begin
        ccr_q <= {alu_c, alu_n, alu_z};
      end else if (op_q == OP_NOT) begin
        ccr_q <= {1'b0, alu_n, alu_z};
      end
    end
  end

  assign ccr = ccr_q;
`else
  logic unused_flags;
  assign unused_flags = ^{alu_c, alu_n, alu_z};
  assign ccr          = 3'b000;
`endif

endmodule
